// File: rtl/mchan_arb_pkg.sv
// Shared types for the multi-channel round-robin arbiter: output buffer entry
// layout (default-configuration widths) and the lock FSM state encoding.
package mchan_arb_pkg;

    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned ARB_ID_W   = 4;
    localparam int unsigned ARB_IDX_W  = 2;

    typedef struct packed {
        logic [ARB_DATA_W-1:0] data;
        logic [ARB_ID_W-1:0]   id;
        logic [ARB_IDX_W-1:0]  idx;
    } arb_entry_t;

    typedef enum logic [0:0] {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/mchan_arb_out_buf.sv
// Two-entry output FIFO with registered head, valid and full indications.
// The entry type is a parameter so the top can size it to its own widths.
module mchan_arb_out_buf
    import mchan_arb_pkg::*;
#(
    parameter type entry_t = arb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output logic   valid,
    output logic   full,
    output entry_t head
);

    entry_t     mem_r [2];
    entry_t     mem_nxt_s [2];
    entry_t     head_r;
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic       wr_nxt_s;
    logic       rd_nxt_s;
    logic [1:0] count_r;
    logic [1:0] cnt_nxt_s;
    logic       valid_r;
    logic       push_s;
    logic       pop_s;

    // Next-state computation for storage, pointers and occupancy.
    always_comb begin
        mem_nxt_s = mem_r;
        wr_nxt_s  = wr_ptr_r;
        rd_nxt_s  = rd_ptr_r;
        push_s    = push && (count_r != 2'd2);
        pop_s     = pop && (count_r != 2'd0);
        if (push_s) begin
            mem_nxt_s[wr_ptr_r] = push_entry;
            wr_nxt_s            = ~wr_ptr_r;
        end else begin
            wr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_nxt_s = ~rd_ptr_r;
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = count_r + 2'd1;
            2'b01:   cnt_nxt_s = count_r - 2'd1;
            default: cnt_nxt_s = count_r;
        endcase
    end

    // State registers; head and valid are loaded from next state so outputs stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            head_r   <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            valid_r  <= 1'b0;
        end else begin
            mem_r    <= mem_nxt_s;
            head_r   <= mem_nxt_s[rd_nxt_s];
            wr_ptr_r <= wr_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            count_r  <= cnt_nxt_s;
            valid_r  <= (cnt_nxt_s != 2'd0);
        end
    end

    assign valid = valid_r;
    assign full  = (count_r == 2'd2);
    assign head  = head_r;

endmodule

// File: rtl/mchan_rr_arb_sched.sv
// Round-robin arbiter feeding a 2-entry output buffer with 1-cycle latency.
// Define MCHAN_ARB_LOCK_EN to add per-requester lock (grant holding) support.
module mchan_rr_arb_sched
    import mchan_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_REQ-1:0]                    req_i,
    output logic [N_REQ-1:0]                    gnt_o,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    data_i,
    input  logic [N_REQ-1:0][ID_WIDTH-1:0]      id_i,
`ifdef MCHAN_ARB_LOCK_EN
    input  logic [N_REQ-1:0]                    lock_i,
`endif
    output logic                                req_o,
    input  logic                                gnt_i,
    output logic [DATA_WIDTH-1:0]               data_o,
    output logic [ID_WIDTH-1:0]                 id_o,
    output logic [$clog2(N_REQ)-1:0]            port_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        logic [IDX_W-1:0]      idx;
    } entry_t;

    logic [IDX_W-1:0] ptr_r;
    logic [N_REQ-1:0] elig_s;
    logic [N_REQ-1:0] gnt_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             win_found_s;
    logic             in_xfer_s;
    logic             buf_full_s;
    logic             buf_valid_s;
    entry_t           push_entry_s;
    entry_t           head_s;

`ifdef MCHAN_ARB_LOCK_EN
    lock_state_e      lock_state_r;
    logic [IDX_W-1:0] lock_owner_r;

    // While locked only the owner is eligible.
    always_comb begin
        elig_s = {N_REQ{1'b0}};
        if (lock_state_r == LOCK_LOCKED) begin
            elig_s[lock_owner_r] = req_i[lock_owner_r];
        end else begin
            elig_s = req_i;
        end
    end

    // Lock FSM: a locked transfer claims the arbiter, an unlocked owner transfer releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state_r <= LOCK_UNLOCKED;
            lock_owner_r <= IDX_ZERO;
        end else begin
            case (lock_state_r)
                LOCK_UNLOCKED: begin
                    if (in_xfer_s && lock_i[win_idx_s]) begin
                        lock_state_r <= LOCK_LOCKED;
                        lock_owner_r <= win_idx_s;
                    end
                end
                LOCK_LOCKED: begin
                    if (in_xfer_s && !lock_i[win_idx_s]) begin
                        lock_state_r <= LOCK_UNLOCKED;
                    end
                end
                default: begin
                    lock_state_r <= LOCK_UNLOCKED;
                    lock_owner_r <= IDX_ZERO;
                end
            endcase
        end
    end
`else
    // Pure round robin: every request is eligible.
    always_comb begin
        elig_s = req_i;
    end
`endif

    // First eligible index at or after ptr, wrapping through the power-of-2 index width.
    always_comb begin
        logic [IDX_W-1:0] cand_v;
        cand_v      = IDX_ZERO;
        win_found_s = 1'b0;
        win_idx_s   = IDX_ZERO;
        for (int i = 0; i < N_REQ; i++) begin
            cand_v = ptr_r + IDX_W'(i);
            if (!win_found_s && elig_s[cand_v]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_v;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Grant is suppressed in reset and whenever the buffer is full.
    always_comb begin
        gnt_s = {N_REQ{1'b0}};
        if (win_found_s && !buf_full_s && rst_n) begin
            gnt_s[win_idx_s] = 1'b1;
        end else begin
            gnt_s = {N_REQ{1'b0}};
        end
    end

    assign in_xfer_s = |gnt_s;
    assign gnt_o     = gnt_s;

    // Capture the winning requester's payload for the buffer.
    always_comb begin
        push_entry_s.data = data_i[win_idx_s];
        push_entry_s.id   = id_i[win_idx_s];
        push_entry_s.idx  = win_idx_s;
    end

    // Round-robin pointer moves past the winner only on an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= IDX_ZERO;
        end else if (in_xfer_s) begin
            ptr_r <= win_idx_s + IDX_ONE;
        end
    end

    mchan_arb_out_buf #(
        .entry_t (entry_t)
    ) u_out_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (in_xfer_s),
        .push_entry (push_entry_s),
        .pop        (gnt_i),
        .valid      (buf_valid_s),
        .full       (buf_full_s),
        .head       (head_s)
    );

    assign req_o  = buf_valid_s;
    assign data_o = head_s.data;
    assign id_o   = head_s.id;
    assign port_o = head_s.idx;

endmodule
